// File: rtl/image_stream_if.sv
// Pixel stream link between the host-side transmitter and the conv/DNN
// pipeline input: valid/data forward, ready/done back from the pipeline.
interface image_stream_if #(
    parameter int BitSize = 32
);
    logic               out_valid;
    logic [BitSize-1:0] out_data;
    logic               in_ready;
    logic               in_done;

    // Transmitter side drives the beat, pipeline side answers with ready/done.
    modport master (output out_valid, out_data, input in_ready, in_done);
    modport slave  (input out_valid, out_data, output in_ready, in_done);
endinterface

// File: rtl/image_stream_tx.sv
// Host-side frame transmitter: buffers one ImageWidth x ImageWidth frame
// written by the host, streams it row-major into the pipeline on start,
// then waits for the pipeline's done indication under a watchdog.
module image_stream_tx #(
    parameter int BitSize     = 32,
    parameter int ImageWidth  = 8,
    parameter int AddrBits    = $clog2(ImageWidth * ImageWidth),
    parameter int DoneTimeout = 4096
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic                host_wr_en,
    input  logic [AddrBits-1:0] host_wr_addr,
    input  logic [BitSize-1:0]  host_wr_data,
    input  logic                start,
    image_stream_if.master      pix,
    output logic                busy,
    output logic                frame_done,
    output logic                timeout
);
    localparam int Pixels = ImageWidth * ImageWidth;
    localparam int TW     = $clog2(DoneTimeout + 1);

    localparam logic [31:0]         PIXELS_U  = 32'(Pixels);
    localparam logic [AddrBits-1:0] FIRST_PIX = '0;
    localparam logic [AddrBits-1:0] LAST_PIX  = AddrBits'(Pixels - 1);
    localparam logic [TW-1:0]       LAST_WAIT = TW'(DoneTimeout - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_DONE
    } state_t;

    state_t              state;
    logic [AddrBits-1:0] pix_idx;
    logic [AddrBits-1:0] pix_next;
    logic [TW-1:0]       wait_cnt;
    logic [BitSize-1:0]  frame_buf [Pixels];
    logic                wr_ok;

    assign pix_next = pix_idx + 1'b1;

    // Host writes land only while idle and not racing a start, and only in range.
    assign wr_ok = host_wr_en && !res_n && (state == IDLE) && !start
                   && (32'(host_wr_addr) < PIXELS_U);

    // Frame buffer write port; contents survive reset so a frame can be replayed.
    // NOTE: the buffer has no reset branch on purpose -- resetting a memory array
    // turns it into a huge register bank and would also destroy the stored frame.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            frame_buf[host_wr_addr] <= host_wr_data;
        end
    end

    // Transmit FSM with registered stream and status outputs.
    // NOTE: every state and output register here uses non-blocking assignment so
    // all of them update together from the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (res_n) begin
            state         <= IDLE;
            pix.out_valid <= 1'b0;
            pix.out_data  <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            timeout       <= 1'b0;
            pix_idx       <= '0;
            wait_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= STREAM;
                        pix.out_valid <= 1'b1;
                        pix.out_data  <= frame_buf[FIRST_PIX];
                        pix_idx       <= FIRST_PIX;
                        busy          <= 1'b1;
                        timeout       <= 1'b0;
                    end
                end
                STREAM: begin
                    // out_valid is always high here, so ready alone marks a transfer.
                    if (pix.in_ready) begin
                        if (pix_idx == LAST_PIX) begin
                            state         <= WAIT_DONE;
                            pix.out_valid <= 1'b0;
                            wait_cnt      <= '0;
                        end else begin
                            pix_idx      <= pix_next;
                            pix.out_data <= frame_buf[pix_next];
                        end
                    end
                end
                WAIT_DONE: begin
                    if (pix.in_done) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        timeout    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    pix.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/image_stream_tx.md
Name: image_stream_tx

Overview:
- Host-side transmitter feeding the conv/pooling + DNN pipeline input (pixel valid/data, pipeline ready, pipeline done).
- Holds one ImageWidth x ImageWidth frame in an internal buffer loaded by the host.
- On start, streams the frame row-major, one pixel per accepted beat, honouring pipeline ready.
- Then waits for the pipeline's done indication, with a watchdog timeout.

Parameters:
- BitSize, 32, pixel word width (matches pipeline data width).
- ImageWidth, 8, frame side length; Pixels = ImageWidth*ImageWidth.
- AddrBits, $clog2(ImageWidth*ImageWidth), host write address width.
- DoneTimeout, 4096, max cycles spent in WAIT_DONE before aborting; must be >= 1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res_n  in  1  reset, synchronous, active-high (1 = reset).
- host_wr_en  in  1  host buffer write strobe.
- host_wr_addr  in  AddrBits  pixel index to write.
- host_wr_data  in  BitSize  pixel value.
- start  in  1  one-cycle pulse: begin streaming the buffered frame.
- out_valid  out  1  pixel beat valid; connects to pipeline in_valid.
- out_data  out  BitSize  pixel value; connects to pipeline in_data.
- in_ready  in  1  pipeline ready; connects to pipeline out_ready.
- in_done  in  1  pipeline done; connects to pipeline out_done.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse when a frame completes or times out.
- timeout  out  1  sticky flag: last frame ended by watchdog.

Behaviour:
- Reset (res_n=1 at edge):
  - state=IDLE; out_valid=0, out_data=0, busy=0, frame_done=0, timeout=0; pixel and timeout counters=0.
  - Frame buffer is NOT cleared; contents are preserved across reset.
  - Reset takes priority over every other input, in any state.
- Buffer writes:
  - Accepted only when state=IDLE, start=0 and host_wr_addr < Pixels; otherwise silently dropped.
  - Writes issued in the same cycle as start are dropped.
- States: IDLE, STREAM, WAIT_DONE.
- IDLE:
  - start=1 -> STREAM; next cycle out_valid=1, out_data=buf[0], pixel index=0.
  - timeout is cleared on this transition.
  - start is ignored in any other state.
- STREAM:
  - A beat transfers on an edge where out_valid=1 and in_ready=1.
  - While in_ready=0, out_valid and out_data hold stable.
  - On a transfer of pixel k < Pixels-1: next cycle out_data=buf[k+1], out_valid stays 1.
  - On a transfer of pixel Pixels-1: next cycle out_valid=0, state=WAIT_DONE, timeout counter=0.
  - in_done is ignored in STREAM.
  - Zero-bubble: with in_ready held high, pixels appear on consecutive cycles; latency start -> first beat = 1 cycle.
- WAIT_DONE:
  - out_valid=0.
  - in_done=1 -> next cycle IDLE, frame_done=1 for one cycle.
  - Otherwise the counter increments; on the edge where counter == DoneTimeout-1 and in_done=0 -> next cycle IDLE, timeout=1, frame_done=1.
  - Done and timeout reached in the same cycle: done wins, timeout stays 0.
- frame_done is registered, asserted for exactly one cycle, coincident with busy falling.
- Reset mid-STREAM or mid-WAIT_DONE aborts the frame with no frame_done pulse.
- A subsequent start restreams from pixel 0 using the preserved buffer.

Test Plan:
- Write buf[i]=i+1 for i=0..63, start at cycle 0, in_ready=1 -> out_valid=1 cycles 1..64 with out_data=1..64; out_valid=0 at cycle 65. Drive in_done at cycle 70 -> frame_done=1 and busy=0 at cycle 71 only; timeout=0.
- Same frame, in_ready=0 cycles 5..9 -> out_data=5 held cycles 5..10, transferred at 10; last beat (64) at cycle 69; no pixel skipped or duplicated.
- DoneTimeout=16, in_done never asserted -> after 16 WAIT_DONE cycles: frame_done pulse, timeout=1, busy=0. Next start clears timeout.
- During STREAM: pulse start, write addr 0 with 0xDEAD, pulse in_done -> all ignored; stream continues unchanged. After return to IDLE, buf[0] still 1.
- Assert res_n at beat 30 -> next cycle out_valid=0, busy=0, no frame_done. Then start -> first beat out_data=1 (buffer preserved).
- DoneTimeout=16, in_done rises on the 16th WAIT_DONE cycle -> frame_done=1, timeout=0.
